// File: rtl/pic_fetch_decode_pkg.sv
// Shared definitions for the PIC16 mid-range fetch/decode slice:
// ALU operation codes, instruction classes, fixed encodings and the
// opcode classification helpers used by the execute-stage decoder.
package pic_fetch_decode_pkg;

   localparam int INSTR_W = 14;

   // Fixed single-word encodings
   localparam logic [INSTR_W-1:0] NOP_WORD    = 14'h0000;
   localparam logic [INSTR_W-1:0] RETURN_WORD = 14'h0008;
   localparam logic [INSTR_W-1:0] RETFIE_WORD = 14'h0009;
   localparam logic [INSTR_W-1:0] SLEEP_WORD  = 14'h0063;
   localparam logic [INSTR_W-1:0] CLRWDT_WORD = 14'h0064;

   // Instruction-class patterns on IR[13:7] (x = don't care)
   localparam logic [6:0] PAT_MOVWF  = 7'b0000001;
   localparam logic [6:0] PAT_CLRF   = 7'b0000011;
   localparam logic [6:0] PAT_CLRW   = 7'b0000010;
   localparam logic [6:0] PAT_DECFSZ = 7'b001011?;
   localparam logic [6:0] PAT_INCFSZ = 7'b001111?;
   localparam logic [6:0] PAT_BYTE   = 7'b00?????;
   localparam logic [6:0] PAT_BCF    = 7'b0100???;
   localparam logic [6:0] PAT_BSF    = 7'b0101???;
   localparam logic [6:0] PAT_BTFSC  = 7'b0110???;
   localparam logic [6:0] PAT_BTFSS  = 7'b0111???;
   localparam logic [6:0] PAT_CALL   = 7'b100????;
   localparam logic [6:0] PAT_GOTO   = 7'b101????;
   localparam logic [6:0] PAT_RETLW  = 7'b1101???;
   localparam logic [6:0] PAT_LITBAD = 7'b111011?;
   localparam logic [6:0] PAT_LIT    = 7'b11?????;

   // ALU operation codes driven on CB
   typedef enum logic [4:0] {
      INOP   = 5'd0,
      IPASSW = 5'd1,
      ICLR   = 5'd2,
      ISUB   = 5'd3,
      IDEC   = 5'd4,
      IIOR   = 5'd5,
      IAND   = 5'd6,
      IXOR   = 5'd7,
      IADD   = 5'd8,
      IPASSF = 5'd9,
      ICOM   = 5'd10,
      IINC   = 5'd11,
      IRRF   = 5'd12,
      IRLF   = 5'd13,
      ISWAP  = 5'd14,
      IBCF   = 5'd15,
      IBSF   = 5'd16,
      IBTST  = 5'd17,
      IPASSK = 5'd18
   } alu_op_t;

   // Decoded instruction classes seen by the execute stage
   typedef enum logic [3:0] {
      C_NONE,
      C_MOVWF,
      C_CLRF,
      C_CLRW,
      C_BYTE,
      C_SKIPF,
      C_BCF,
      C_BSF,
      C_BTFSC,
      C_BTFSS,
      C_CALL,
      C_GOTO,
      C_RETURN,
      C_RETLW,
      C_LIT
   } instr_class_t;

   // Classify an instruction word; the chain order resolves overlapping patterns
   function automatic instr_class_t classify(input logic [INSTR_W-1:0] ir);
      instr_class_t c;
      logic [6:0]   hi;
      hi = ir[13:7];
      c  = C_NONE;
      if (ir == RETURN_WORD)                                   c = C_RETURN;
      else if (ir == NOP_WORD    || ir == RETFIE_WORD ||
               ir == SLEEP_WORD  || ir == CLRWDT_WORD)          c = C_NONE;
      else if (hi ==? PAT_MOVWF)                                c = C_MOVWF;
      else if (hi ==? PAT_CLRF)                                 c = C_CLRF;
      else if (hi ==? PAT_CLRW)                                 c = C_CLRW;
      else if (hi == 7'b0000000)                                c = C_NONE;
      else if (hi ==? PAT_DECFSZ || hi ==? PAT_INCFSZ)          c = C_SKIPF;
      else if (hi ==? PAT_BYTE)                                 c = C_BYTE;
      else if (hi ==? PAT_BCF)                                  c = C_BCF;
      else if (hi ==? PAT_BSF)                                  c = C_BSF;
      else if (hi ==? PAT_BTFSC)                                c = C_BTFSC;
      else if (hi ==? PAT_BTFSS)                                c = C_BTFSS;
      else if (hi ==? PAT_CALL)                                 c = C_CALL;
      else if (hi ==? PAT_GOTO)                                 c = C_GOTO;
      else if (hi ==? PAT_RETLW)                                c = C_RETLW;
      else if (hi ==? PAT_LITBAD)                               c = C_NONE;
      else if (hi ==? PAT_LIT)                                  c = C_LIT;
      return c;
   endfunction

   // ALU operation for a byte-oriented file instruction, keyed by IR[11:8]
   function automatic alu_op_t byte_alu_op(input logic [3:0] op);
      alu_op_t a;
      case (op)
         4'h2:    a = ISUB;
         4'h3:    a = IDEC;
         4'h4:    a = IIOR;
         4'h5:    a = IAND;
         4'h6:    a = IXOR;
         4'h7:    a = IADD;
         4'h8:    a = IPASSF;
         4'h9:    a = ICOM;
         4'hA:    a = IINC;
         4'hB:    a = IDEC;
         4'hC:    a = IRRF;
         4'hD:    a = IRLF;
         4'hE:    a = ISWAP;
         4'hF:    a = IINC;
         default: a = INOP;
      endcase
      return a;
   endfunction

   // ALU operation for a literal instruction, keyed by IR[11:8]
   function automatic alu_op_t lit_alu_op(input logic [3:0] op);
      alu_op_t a;
      a = INOP;
      if (op ==? 4'b0???)       a = IPASSK;
      else if (op == 4'b1000)   a = IIOR;
      else if (op == 4'b1001)   a = IAND;
      else if (op == 4'b1010)   a = IXOR;
      else if (op ==? 4'b110?)  a = ISUB;
      else if (op ==? 4'b111?)  a = IADD;
      return a;
   endfunction

endpackage

// File: rtl/pic_stack.sv
// Circular return-address stack. A push past the last entry silently
// overwrites the oldest one; a pop on an empty stack just wraps the
// pointer and exposes whatever was left there.
module pic_stack
   import pic_fetch_decode_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;

   assign top_idx = ptr - PTR_W'(1);
   assign top     = mem[top_idx];

   // Pointer and entry updates; push writes at the pointer then advances it
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[ptr] <= push_data;
         ptr      <= ptr + PTR_W'(1);
      end else if (pop) begin
         ptr <= top_idx;
      end
   end

endmodule

// File: rtl/pic_fetch_decode.sv
// Two-stage PIC16 mid-range front end: fetch PDATA at PADDR into IR while
// the previous IR is decoded combinationally into ALU/write controls.
// Branches, calls, returns and taken skips replace the fetched word with NOP.
module pic_fetch_decode
   import pic_fetch_decode_pkg::*;
#(
   parameter int PC_W        = 11,
   parameter int STACK_DEPTH = 8,
   parameter int RESET_VEC   = 0
) (
   input  logic            CLK,
   input  logic            RST_N,
   output logic [PC_W-1:0] PADDR,
   input  logic [13:0]     PDATA,
   input  logic            ZERO,
   output logic [4:0]      CB,
   output logic            WE,
   output logic            FWE,
   output logic [2:0]      B,
   output logic [6:0]      FADDR,
   output logic [7:0]      K,
   output logic            LSEL
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] jump_target;
   logic [PC_W-1:0] stack_top;
   logic [13:0]     ir;
   logic [13:0]     ir_next;
   instr_class_t    iclass;
   alu_op_t         alu_op;
   logic            skip;
   logic            stack_push;
   logic            stack_pop;

   assign iclass = classify(ir);
   assign pc_inc = pc + PC_W'(1);

   // GOTO/CALL replace the low eleven PC bits and keep any upper page bits
   generate
      if (PC_W > 11) begin : g_paged_target
         assign jump_target = {pc[PC_W-1:11], ir[10:0]};
      end else begin : g_flat_target
         assign jump_target = ir[PC_W-1:0];
      end
   endgenerate

   assign PADDR = pc;
   assign B     = ir[9:7];
   assign FADDR = ir[6:0];
   assign K     = ir[7:0];
   assign CB    = alu_op;

   // Execute-stage decode of IR into ALU operation and write enables
   always_comb begin
      alu_op = INOP;
      WE     = 1'b0;
      FWE    = 1'b0;
      LSEL   = 1'b0;
      case (iclass)
         C_MOVWF: begin
            alu_op = IPASSW;
            FWE    = 1'b1;
         end
         C_CLRF: begin
            alu_op = ICLR;
            FWE    = 1'b1;
         end
         C_CLRW: begin
            alu_op = ICLR;
            WE     = 1'b1;
         end
         C_BYTE, C_SKIPF: begin
            alu_op = byte_alu_op(ir[11:8]);
            WE     = ~ir[7];
            FWE    = ir[7];
         end
         C_BCF: begin
            alu_op = IBCF;
            FWE    = 1'b1;
         end
         C_BSF: begin
            alu_op = IBSF;
            FWE    = 1'b1;
         end
         C_BTFSC, C_BTFSS: begin
            alu_op = IBTST;
         end
         C_RETLW: begin
            alu_op = IPASSK;
            LSEL   = 1'b1;
            WE     = 1'b1;
         end
         C_LIT: begin
            alu_op = lit_alu_op(ir[11:8]);
            LSEL   = 1'b1;
            WE     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Conditional-skip resolution from the ALU zero flag of the executing op
   always_comb begin
      skip = 1'b0;
      case (iclass)
         C_SKIPF: skip = ZERO;
         C_BTFSC: skip = ZERO;
         C_BTFSS: skip = ~ZERO;
         default: skip = 1'b0;
      endcase
   end

   // Next PC, next IR and stack requests; redirects flush the fetched word
   always_comb begin
      pc_next    = pc_inc;
      ir_next    = PDATA;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      if (iclass == C_GOTO || iclass == C_CALL) begin
         pc_next    = jump_target;
         ir_next    = NOP_WORD;
         stack_push = (iclass == C_CALL);
      end else if (iclass == C_RETURN || iclass == C_RETLW) begin
         pc_next   = stack_top;
         ir_next   = NOP_WORD;
         stack_pop = 1'b1;
      end else if (skip) begin
         ir_next = NOP_WORD;
      end
   end

   // PC and IR registers; reset parks the pipeline on a NOP at the reset vector
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc <= PC_W'(RESET_VEC);
         ir <= NOP_WORD;
      end else begin
         pc <= pc_next;
         ir <= ir_next;
      end
   end

   pic_stack #(
      .WIDTH (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (stack_push),
      .pop       (stack_pop),
      .push_data (pc),
      .top       (stack_top)
   );

endmodule

// File: doc/pic_fetch_decode.md
PIC_FETCH_DECODE -- requirements
Module: pic_fetch_decode

Interface
REQ-001 SHALL have parameter PC_W, default 11, program counter and stack entry width.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of return-stack entries (power of two).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value after reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port PADDR, output, PC_W bits: program memory address, equal to the current PC.
REQ-007 SHALL have port PDATA, input, 14 bits: instruction word, combinationally valid for PADDR in the same cycle.
REQ-008 SHALL have port ZERO, input, 1 bit: ALU zero flag for the instruction in execute.
REQ-009 SHALL have port CB, output, 5 bits: ALU operation code.
REQ-010 SHALL have port WE, output, 1 bit: W register write enable.
REQ-011 SHALL have port FWE, output, 1 bit: file register write enable.
REQ-012 SHALL have port B, output, 3 bits: bit position, IR[9:7].
REQ-013 SHALL have port FADDR, output, 7 bits: file register address, IR[6:0].
REQ-014 SHALL have port K, output, 8 bits: literal, IR[7:0].
REQ-015 SHALL have port LSEL, output, 1 bit: 1 selects K instead of file data as the ALU operand.

Function
REQ-016 SHALL use a two-stage pipeline: fetch (PC -> PDATA captured into IR) overlapped with execute (IR decoded combinationally).
REQ-017 SHALL, each cycle with no redirect, load IR <= PDATA and set PC <= PC+1, wrapping modulo 2^PC_W.
REQ-018 SHALL decode IR per the PIC16 mid-range 14-bit opcode table; byte ops: d=0 asserts WE, d=1 asserts FWE.
REQ-019 SHALL decode CLRF and MOVWF to FWE=1; CLRW to WE=1; BCF/BSF to FWE=1; literal ops (MOVLW, ADDLW, SUBLW, ANDLW, IORLW, XORLW, RETLW) to LSEL=1, WE=1.
REQ-020 SHALL decode NOP, CLRWDT, SLEEP, RETFIE and undefined words to WE=0, FWE=0.
REQ-021 SHALL, for GOTO and CALL, set PC <= {PC[PC_W-1:11], IR[10:0]} at cycle end and load IR <= NOP (14'h0000), flushing the fetched word.
REQ-022 SHALL, for CALL, push PC (the already-incremented return address) in the same cycle.
REQ-023 SHALL, for RETURN and RETLW, pop the stack into PC and flush IR to NOP; RETLW also writes K to W.
REQ-024 SHALL, for DECFSZ/INCFSZ with ZERO=1, BTFSC with ZERO=1, BTFSS with ZERO=0, load IR <= NOP while PC increments normally.
REQ-025 SHALL implement the stack as circular: a push beyond STACK_DEPTH overwrites the oldest entry; a pop when empty wraps the pointer and returns stale data; no overflow flag.
REQ-026 SHALL gate WE/FWE only by the decode of IR; a flushed slot is NOP, so no write occurs.
REQ-027 SHALL leave PCL writes, interrupts and paging beyond PC_W out of scope.

Reset
REQ-028 SHALL, while RST_N=0, hold PC=RESET_VEC, IR=NOP, stack pointer=0, stack contents=0; outputs WE=0, FWE=0, LSEL=0, PADDR=RESET_VEC.
REQ-029 SHALL, after reset release, execute NOP in the first cycle while fetching RESET_VEC.
REQ-030 SHALL abandon any in-flight branch, skip or stack operation on reset assertion mid-operation.

Structure
REQ-031 SHALL take ALU operation codes from the shared alu_op.v definitions; instruction-class patterns and NOP encoding SHALL be added there.
REQ-032 SHALL isolate the return stack in one sub-module, pic_stack (push, pop, top, circular pointer).

Verification
REQ-033 Reset release with sequential NOPs -> PADDR 0,1,2,3; WE=FWE=0 throughout.
REQ-034 ADDWF 0x20,0 (14'h0720) in IR -> CB=IADD, FADDR=0x20, WE=1, FWE=0, LSEL=0.
REQ-035 GOTO 0x123 (14'h2923) fetched at 0x005 -> next PADDR=0x123; word fetched at 0x006 executes as NOP.
REQ-036 CALL 0x050 at 0x010, then RETURN (14'h0008) at 0x050 -> PADDR returns to 0x011; RETLW 0x55 -> K=0x55, LSEL=1, WE=1, PC pops.
REQ-037 DECFSZ with ZERO=1 -> following instruction nullified (WE=FWE=0); ZERO=0 -> it executes; BTFSS mirrors with inverted ZERO.
REQ-038 Nine nested CALLs then nine RETURNs -> first eight return correctly; ninth return yields the ninth-pushed address (wrap).
